// File: rtl/game_ctrl.sv
// Game-flow controller: start/play/hit/over sequencing, lives, saturating score
// and enemy-kill pulses. Collisions are gathered per pixel and acted on at frame_i.
module game_ctrl #(
    parameter int unsigned LIVES_INIT = 3,
    parameter int unsigned HIT_FRAMES = 60,
    parameter int unsigned SCORE_MAX  = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        frame_i,
    input  logic        disp_i,
    input  logic        me_alpha_i,
    input  logic        enemy1_alpha_i,
    input  logic        bullet_alpha_i,
    output logic [1:0]  state_o,
    output logic        run_en_o,
    output logic        blink_o,
    output logic        enemy_kill_o,
    output logic [1:0]  lives_o,
    output logic [13:0] score_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_HIT  = 2'd2,
        S_OVER = 2'd3
    } state_t;

    localparam logic [1:0]  LIVES_L = 2'(LIVES_INIT);
    localparam logic [7:0]  HIT_L   = 8'(HIT_FRAMES);
    localparam logic [13:0] SMAX_L  = 14'(SCORE_MAX);

    state_t      state_q, state_d;
    logic [1:0]  lives_q, lives_d;
    logic [13:0] score_q, score_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        phit_q, phit_d;
    logic        ehit_q, ehit_d;
    logic        start_q, start_d;
    logic        arm_q, arm_d;
    logic        kill_q, kill_d;
    logic        run_en_q, run_en_d;
    logic        blink_q, blink_d;
    logic        start_evt;

    // arm_q stays low after reset until start_i is seen low, so a button held
    // through reset cannot produce a start edge.
    assign start_evt = start_i & ~start_q & arm_q;

    always_comb begin
        // NOTE: every next-state signal gets a default here so no latch is inferred.
        state_d = state_q;
        lives_d = lives_q;
        score_d = score_q;
        cnt_d   = cnt_q;
        kill_d  = 1'b0;
        start_d = start_i;
        arm_d   = arm_q | ~start_i;

        if (frame_i) begin
            phit_d = 1'b0;
            ehit_d = 1'b0;
        end else begin
            phit_d = phit_q | (disp_i & me_alpha_i & enemy1_alpha_i);
            ehit_d = ehit_q | (disp_i & bullet_alpha_i & enemy1_alpha_i);
        end

        case (state_q)
            S_IDLE: begin
                if (start_evt) begin
                    state_d = S_PLAY;
                    lives_d = LIVES_L;
                    score_d = '0;
                    cnt_d   = '0;
                    phit_d  = 1'b0;
                    ehit_d  = 1'b0;
                end
            end
            S_PLAY, S_HIT: begin
                if (frame_i) begin
                    if (ehit_q) begin
                        kill_d = 1'b1;
                        if (score_q < SMAX_L) score_d = score_q + 14'd1;
                    end
                    if (state_q == S_HIT) begin
                        // Hits are ignored while invulnerable.
                        if (cnt_q <= 8'd1) begin
                            cnt_d   = '0;
                            state_d = S_PLAY;
                        end else begin
                            cnt_d = cnt_q - 8'd1;
                        end
                    end else if (phit_q) begin
                        if (lives_q <= 2'd1) begin
                            lives_d = '0;
                            state_d = S_OVER;
                        end else begin
                            lives_d = lives_q - 2'd1;
                            cnt_d   = HIT_L;
                            state_d = S_HIT;
                        end
                    end
                end
            end
            S_OVER: begin
                if (start_evt) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        run_en_d = (state_d == S_PLAY) || (state_d == S_HIT);
        blink_d  = (state_d == S_HIT) & cnt_d[0];
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            lives_q  <= '0;
            score_q  <= '0;
            cnt_q    <= '0;
            phit_q   <= 1'b0;
            ehit_q   <= 1'b0;
            start_q  <= 1'b0;
            arm_q    <= 1'b0;
            kill_q   <= 1'b0;
            run_en_q <= 1'b0;
            blink_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            lives_q  <= lives_d;
            score_q  <= score_d;
            cnt_q    <= cnt_d;
            phit_q   <= phit_d;
            ehit_q   <= ehit_d;
            start_q  <= start_d;
            arm_q    <= arm_d;
            kill_q   <= kill_d;
            run_en_q <= run_en_d;
            blink_q  <= blink_d;
        end
    end

    assign state_o      = state_q;
    assign run_en_o     = run_en_q;
    assign blink_o      = blink_q;
    assign enemy_kill_o = kill_q;
    assign lives_o      = lives_q;
    assign score_o      = score_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: directed scenarios followed by random
// stimulus, every cycle compared against a frame-level game model.
module tb_game_ctrl;

    localparam int LIVES = 3;
    localparam int HITF  = 60;
    localparam int SMAX  = 9999;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_i = 1'b0, frame_i = 1'b0, disp_i = 1'b0;
    logic        me_alpha_i = 1'b0, enemy1_alpha_i = 1'b0, bullet_alpha_i = 1'b0;
    logic [1:0]  state_o;
    logic        run_en_o, blink_o, enemy_kill_o;
    logic [1:0]  lives_o;
    logic [13:0] score_o;

    game_ctrl #(.LIVES_INIT(LIVES), .HIT_FRAMES(HITF), .SCORE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .frame_i(frame_i), .disp_i(disp_i),
        .me_alpha_i(me_alpha_i), .enemy1_alpha_i(enemy1_alpha_i),
        .bullet_alpha_i(bullet_alpha_i), .state_o(state_o), .run_en_o(run_en_o),
        .blink_o(blink_o), .enemy_kill_o(enemy_kill_o), .lives_o(lives_o), .score_o(score_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Game model: 0 idle, 1 play, 2 hit, 3 over.
    int m_state, m_lives, m_score, m_inv;
    bit m_phit, m_ehit, m_prev, m_armed, m_kill;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        check("state", int'(state_o), m_state);
        check("run_en", int'(run_en_o), int'(m_state == 1 || m_state == 2));
        check("blink", int'(blink_o), int'(m_state == 2 && (m_inv % 2) == 1));
        check("kill", int'(enemy_kill_o), int'(m_kill));
        check("lives", int'(lives_o), m_lives);
        check("score", int'(score_o), m_score);
    endtask

    task automatic model_reset();
        m_state = 0; m_lives = 0; m_score = 0; m_inv = 0;
        m_phit = 0; m_ehit = 0; m_prev = 0; m_armed = 0; m_kill = 0;
    endtask

    task automatic model(input bit s, f, d, me, en, bu);
        bit evt, ph, eh;
        evt = s && !m_prev && m_armed;
        if (!s) m_armed = 1;
        m_prev = s;
        m_kill = 0;
        ph = m_phit;
        eh = m_ehit;
        if (f) begin
            m_phit = 0;
            m_ehit = 0;
        end else begin
            m_phit = m_phit | (d & me & en);
            m_ehit = m_ehit | (d & bu & en);
        end
        case (m_state)
            0: if (evt) begin
                m_state = 1; m_lives = LIVES; m_score = 0; m_inv = 0;
                m_phit = 0; m_ehit = 0;
            end
            1, 2: if (f) begin
                if (eh) begin
                    m_kill = 1;
                    m_score = (m_score + 1 > SMAX) ? SMAX : m_score + 1;
                end
                if (m_state == 2) begin
                    m_inv = m_inv - 1;
                    if (m_inv == 0) m_state = 1;
                end else if (ph) begin
                    m_lives = m_lives - 1;
                    if (m_lives == 0) m_state = 3;
                    else begin
                        m_state = 2;
                        m_inv = HITF;
                    end
                end
            end
            default: if (evt) m_state = 0;
        endcase
    endtask

    task automatic step(input bit s, f, d, me, en, bu);
        start_i = s; frame_i = f; disp_i = d;
        me_alpha_i = me; enemy1_alpha_i = en; bullet_alpha_i = bu;
        model(s, f, d, me, en, bu);
        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    // One frame: a visible overlap cycle (as selected), a quiet cycle, then frame_i.
    task automatic frames(input int n, input bit me, input bit bu);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 1, me, 1, bu);
            step(0, 0, 1, 0, 0, 0);
            step(0, 1, 0, 0, 0, 0);
        end
    endtask

    task automatic do_reset(input bit s);
        start_i = s; frame_i = 0; disp_i = 0;
        me_alpha_i = 0; enemy1_alpha_i = 0; bullet_alpha_i = 0;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset with start held high: no start must occur after release.
        do_reset(1);
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        check("held_start_idle", int'(state_o), 0);

        // Fresh start edge.
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("start_state", int'(state_o), 1);
        check("start_lives", int'(lives_o), 3);
        check("start_score", int'(score_o), 0);
        check("start_run", int'(run_en_o), 1);
        step(0, 0, 0, 0, 0, 0);

        // Enemy destroyed by bullet.
        step(0, 0, 1, 0, 1, 1);
        step(0, 1, 0, 0, 0, 0);
        check("kill_score", int'(score_o), 1);
        check("kill_pulse", int'(enemy_kill_o), 1);
        step(0, 0, 0, 0, 0, 0);
        check("kill_one_cycle", int'(enemy_kill_o), 0);

        // Overlap outside visible area, or only on the frame cycle, is ignored.
        step(0, 0, 0, 1, 1, 1);
        step(0, 1, 1, 1, 1, 1);
        step(0, 1, 0, 0, 0, 0);
        check("ignore_lives", int'(lives_o), 3);
        check("ignore_score", int'(score_o), 1);

        // Player hit, invulnerability with repeated overlaps, recovery.
        frames(1, 1, 0);
        check("hit_lives", int'(lives_o), 2);
        check("hit_state", int'(state_o), 2);
        frames(59, 1, 0);
        check("hit_still", int'(state_o), 2);
        frames(1, 1, 0);
        check("hit_recover", int'(state_o), 1);
        check("hit_lives_kept", int'(lives_o), 2);

        // Two more hits end the game, then two start presses replay.
        frames(1, 1, 0);
        frames(HITF, 0, 0);
        frames(1, 1, 0);
        check("over_state", int'(state_o), 3);
        check("over_lives", int'(lives_o), 0);
        check("over_run", int'(run_en_o), 0);
        frames(2, 1, 1);
        check("over_score_hold", int'(score_o), 1);
        step(1, 0, 0, 0, 0, 0);
        check("over_to_idle", int'(state_o), 0);
        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        check("replay_state", int'(state_o), 1);
        check("replay_lives", int'(lives_o), 3);
        check("replay_score", int'(score_o), 0);
        step(0, 0, 0, 0, 0, 0);

        // Start presses during play are ignored.
        step(1, 0, 0, 0, 0, 0);
        check("start_in_play", int'(state_o), 1);
        step(0, 0, 0, 0, 0, 0);

        // Drive score to saturation.
        for (int i = 0; i < SMAX; i++) begin
            step(0, 0, 1, 0, 1, 1);
            step(0, 1, 0, 0, 0, 0);
        end
        check("sat_reach", int'(score_o), 9999);
        step(0, 0, 1, 1, 1, 1);
        step(0, 1, 0, 0, 0, 0);
        check("sat_hold", int'(score_o), 9999);
        check("sat_kill", int'(enemy_kill_o), 1);
        check("sat_lives", int'(lives_o), 2);
        check("sat_state", int'(state_o), 2);

        // Random play, with one reset in the middle.
        for (int i = 0; i < 4000; i++) begin
            bit s, f;
            if (i == 2000) do_reset(start_i);
            s = ($urandom_range(0, 11) == 0) ? !start_i : start_i;
            f = ($urandom_range(0, 4) == 0);
            step(s, f, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter LIVES_INIT, default 3, lives loaded on game start (1..3).
REQ-002 Parameter HIT_FRAMES, default 60, invulnerability length in frames after player hit (1..255).
REQ-003 Parameter SCORE_MAX, default 9999, saturation value of score.
REQ-004 clk  input  1  single system clock (pixel clock domain); all logic on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start_i  input  1  start button level, already synchronous to clk.
REQ-007 frame_i  input  1  one-cycle pulse marking frame boundary (vertical blanking start).
REQ-008 disp_i  input  1  high while the current pixel is in the visible area.
REQ-009 me_alpha_i  input  1  player sprite opaque at the current pixel.
REQ-010 enemy1_alpha_i  input  1  enemy sprite opaque at the current pixel.
REQ-011 bullet_alpha_i  input  1  bullet sprite opaque at the current pixel.
REQ-012 state_o  output  2  game state: 0 IDLE, 1 PLAY, 2 HIT, 3 OVER.
REQ-013 run_en_o  output  1  high in PLAY and HIT; gates object motion.
REQ-014 blink_o  output  1  high in HIT on odd frames of the invulnerability count; player sprite hidden when high.
REQ-015 enemy_kill_o  output  1  one-cycle pulse: enemy destroyed, enemy block respawns.
REQ-016 lives_o  output  2  remaining lives.
REQ-017 score_o  output  14  binary score.

Function
REQ-018 start_i SHALL be edge-detected internally; only a 0->1 transition counts as a start event; a level held high yields one event.
REQ-019 Player-hit flag SHALL set on any cycle with disp_i & me_alpha_i & enemy1_alpha_i; enemy-hit flag on any cycle with disp_i & bullet_alpha_i & enemy1_alpha_i.
REQ-020 Both flags SHALL be sampled and cleared on the frame_i cycle; overlap on the frame_i cycle itself is ignored.
REQ-021 All state, lives, score and counter updates SHALL occur only at the frame_i edge (except start events), visible the following cycle.
REQ-022 IDLE: start event -> PLAY, lives := LIVES_INIT, score := 0, hit counter := 0.
REQ-023 PLAY at frame_i: player-hit flag set -> lives decremented; new lives 0 -> OVER, else -> HIT with counter := HIT_FRAMES.
REQ-024 PLAY and HIT at frame_i: enemy-hit flag set -> score +1 saturating at SCORE_MAX, enemy_kill_o pulses the next cycle for exactly one cycle.
REQ-025 Simultaneous player-hit and enemy-hit in one frame SHALL apply both: score increments, kill pulses, lives decrement.
REQ-026 HIT: player-hit flag ignored; counter decrements each frame_i; counter reaching 0 -> PLAY on that same edge.
REQ-027 blink_o SHALL equal counter bit 0 while in HIT, 0 otherwise.
REQ-028 OVER: run_en_o 0; score and lives hold; start event -> IDLE (a second start event required to play again).
REQ-029 Start events in PLAY or HIT SHALL be ignored.
REQ-030 frame_i and a start event in the same IDLE cycle: start takes effect, flags cleared.
REQ-031 Score SHALL never exceed SCORE_MAX nor wrap; lives SHALL never underflow below 0.

Reset
REQ-032 rst high SHALL immediately force state IDLE, run_en_o 0, blink_o 0, enemy_kill_o 0, lives_o 0, score_o 0, counter 0, both flags 0, start edge register 0.
REQ-033 Reset asserted mid-game SHALL abandon the game; after release a fresh 0->1 start_i is required (a held start_i does not restart).

Verification
REQ-034 Reset release, start_i 0->1 -> next cycle state_o=1, lives_o=3, score_o=0, run_en_o=1.
REQ-035 PLAY, one frame with bullet/enemy overlap pixel -> after frame_i score_o=1, enemy_kill_o high exactly 1 cycle.
REQ-036 PLAY, me/enemy overlap -> lives_o=2, state_o=2; further overlaps for 60 frames ignored, blink_o toggles per frame; 60th frame_i -> state_o=1.
REQ-037 Three separated player hits -> lives_o=0, state_o=3, run_en_o=0; start -> IDLE; start -> PLAY, lives_o=3, score_o=0.
REQ-038 score_o=9999 plus enemy hit -> score_o stays 9999, enemy_kill_o still pulses; same frame player hit -> lives decrement.
REQ-039 Overlap asserted with disp_i=0, or only on the frame_i cycle -> no score or lives change.
